// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg: shared types and constants for the sequential binary-to-BCD converter
package bin2bcd_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam int DIG_W = 4;
  localparam logic [DIG_W-1:0] ADJ_TH = 4'd5;
  localparam logic [DIG_W-1:0] ADJ_ADD = 4'd3;
endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: double-dabble digit correction, adds 3 to any digit of 5 or more
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [DIG_W-1:0] d,
  output logic [DIG_W-1:0] q
);
  assign q = (d >= ADJ_TH) ? d + ADJ_ADD : d;
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: one shift-and-add-3 iteration per clock, valid/ready on both sides
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W = 12,
  parameter int DIGITS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BIN_W-1:0]         in_bin,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DIG_W*DIGITS-1:0]  bcd,
  output logic                     ovf,
  output logic [DIGITS-1:0]        blank
);
  localparam int AW = DIG_W * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);
  state_t state, state_n;
  logic [AW-1:0] acc, adj, acc_n;
  logic [BIN_W-1:0] sr, sr_n;
  logic [CW-1:0] cnt;
  logic ovf_acc, carry, last, zero_above;
  logic [DIGITS-1:0] blank_n;
  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (.d(acc[DIG_W*i +: DIG_W]), .q(adj[DIG_W*i +: DIG_W]));
  end
  // the bit leaving the top digit feeds the sticky overflow flag
  assign {carry, acc_n, sr_n} = {adj, sr, 1'b0};
  assign last = (state == SHIFT) && (cnt == CW'(1));
  assign in_ready = (state == IDLE);
  assign out_valid = (state == DONE);
  always_comb begin
    zero_above = 1'b1;
    blank_n = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_above = zero_above && (acc_n[DIG_W*i +: DIG_W] == '0);
      blank_n[i] = zero_above;
    end
  end
  always_comb begin
    state_n = state;
    state_n = (in_ready && in_valid) ? SHIFT :
              last                   ? DONE  :
              (out_valid && out_ready) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
      acc <= '0;
      cnt <= '0;
      ovf_acc <= 1'b0;
      bcd <= '0;
      ovf <= 1'b0;
      blank <= '0;
    end else if (in_ready && in_valid) begin
      sr <= in_bin;
      acc <= '0;
      ovf_acc <= 1'b0;
      cnt <= CW'(BIN_W);
    end else if (state == SHIFT) begin
      sr <= sr_n;
      acc <= acc_n;
      ovf_acc <= ovf_acc | carry;
      cnt <= cnt - 1'b1;
      if (last) begin
        bcd <= acc_n;
        ovf <= ovf_acc | carry;
        blank <= blank_n;
      end
    end
  end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: vector table, corner sequences and randomized scoreboard for bin2bcd_seq
module tb_bin2bcd_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic iv, orr;
  logic [11:0] ib;
  logic rdy, ov, rdy3, ov3, of4, of3;
  logic [15:0] b4;
  logic [11:0] b3;
  logic [3:0] k4;
  logic [2:0] k3;
  int checks = 0, errors = 0, cyc = 0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.BIN_W(12), .DIGITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(rdy), .in_bin(ib),
    .out_valid(ov), .out_ready(orr), .bcd(b4), .ovf(of4), .blank(k4));
  bin2bcd_seq #(.BIN_W(12), .DIGITS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(rdy3), .in_bin(ib),
    .out_valid(ov3), .out_ready(orr), .bcd(b3), .ovf(of3), .blank(k3));

  typedef struct {
    logic [11:0] v;
    logic [15:0] b4;
    logic [3:0]  k4;
    logic [11:0] b3;
    logic        o3;
    logic [2:0]  k3;
  } vec_t;
  vec_t tbl[8];

  function automatic logic [15:0] bcd_of(int v, int d);
    logic [15:0] r = '0;
    int m = v % (10 ** d);
    for (int i = 0; i < d; i++) r[4*i +: 4] = 4'((m / (10 ** i)) % 10);
    return r;
  endfunction

  function automatic logic [3:0] blank_of(int v, int d);
    logic [3:0] r = '0;
    int m = v % (10 ** d);
    for (int i = 1; i < d; i++) r[i] = (m < 10 ** i);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic start(input logic [11:0] v);
    int n = 0;
    iv = 1'b1;
    ib = v;
    while (!rdy && n < 50) begin
      tick;
      n++;
    end
    chk("accept_timeout", 32'(rdy), 32'd1);
    tick;
    iv = 1'b0;
    ib = 12'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!ov && lat < 100) begin
      tick;
      lat++;
    end
  endtask

  task automatic release_out;
    orr = 1'b1;
    tick;
    orr = 1'b0;
  endtask

  initial begin
    int lat, sent, recv, last_acc, v;
    logic will_acc, have_prev;
    int q[$];
    logic [15:0] held_b;
    logic [3:0] held_k;
    iv = 1'b0;
    ib = '0;
    orr = 1'b0;
    tbl[0] = '{12'd4095, 16'h4095, 4'b0000, 12'h095, 1'b1, 3'b100};
    tbl[1] = '{12'd0,    16'h0000, 4'b1110, 12'h000, 1'b0, 3'b110};
    tbl[2] = '{12'd999,  16'h0999, 4'b1000, 12'h999, 1'b0, 3'b000};
    tbl[3] = '{12'd57,   16'h0057, 4'b1100, 12'h057, 1'b0, 3'b100};
    tbl[4] = '{12'd1234, 16'h1234, 4'b0000, 12'h234, 1'b1, 3'b000};
    tbl[5] = '{12'd1000, 16'h1000, 4'b0000, 12'h000, 1'b1, 3'b110};
    tbl[6] = '{12'd10,   16'h0010, 4'b1100, 12'h010, 1'b0, 3'b100};
    tbl[7] = '{12'd5,    16'h0005, 4'b1110, 12'h005, 1'b0, 3'b110};

    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 32'(rdy), 32'd1);
    chk("rst_out_valid", 32'(ov), 32'd0);
    chk("rst_bcd", 32'(b4), 32'd0);
    chk("rst_ovf", 32'(of4), 32'd0);
    chk("rst_blank", 32'(k4), 32'd0);
    tick;
    tick;
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      start(tbl[i].v);
      wait_done(lat);
      chk($sformatf("lat_%0d", tbl[i].v), 32'(lat), 32'd12);
      chk($sformatf("bcd4_%0d", tbl[i].v), 32'(b4), 32'(tbl[i].b4));
      chk($sformatf("ovf4_%0d", tbl[i].v), 32'(of4), 32'd0);
      chk($sformatf("blank4_%0d", tbl[i].v), 32'(k4), 32'(tbl[i].k4));
      chk($sformatf("bcd3_%0d", tbl[i].v), 32'(b3), 32'(tbl[i].b3));
      chk($sformatf("ovf3_%0d", tbl[i].v), 32'(of3), 32'(tbl[i].o3));
      chk($sformatf("blank3_%0d", tbl[i].v), 32'(k3), 32'(tbl[i].k3));
      release_out;
    end

    start(12'd321);
    wait_done(lat);
    held_b = b4;
    held_k = k4;
    chk("bp_bcd_first", 32'(held_b), 32'h0321);
    iv = 1'b1;
    ib = 12'd777;
    for (int c = 0; c < 5; c++) begin
      tick;
      chk("bp_valid", 32'(ov), 32'd1);
      chk("bp_bcd", 32'(b4), 32'(held_b));
      chk("bp_blank", 32'(k4), 32'(held_k));
      chk("bp_ovf", 32'(of4), 32'd0);
      chk("bp_in_ready", 32'(rdy), 32'd0);
    end
    orr = 1'b1;
    tick;
    orr = 1'b0;
    chk("bp_drop_valid", 32'(ov), 32'd0);
    chk("bp_idle_ready", 32'(rdy), 32'd1);
    tick;
    iv = 1'b0;
    chk("bp_second_accepted", 32'(rdy), 32'd0);
    wait_done(lat);
    chk("bp_second_lat", 32'(lat), 32'd12);
    chk("bp_second_bcd", 32'(b4), 32'h0777);
    release_out;

    start(12'd1234);
    for (int c = 0; c < 5; c++) tick;
    #3 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(ov), 32'd0);
    chk("abort_bcd", 32'(b4), 32'd0);
    chk("abort_in_ready", 32'(rdy), 32'd1);
    tick;
    rst_n = 1'b1;
    start(12'd57);
    wait_done(lat);
    chk("post_rst_lat", 32'(lat), 32'd12);
    chk("post_rst_bcd", 32'(b4), 32'h0057);
    release_out;

    sent = 0;
    recv = 0;
    last_acc = 0;
    have_prev = 1'b0;
    while ((sent < 1500 || recv < 1500) && cyc < 80000) begin
      if (!iv && sent < 1500 && $urandom_range(0, 3) == 0) begin
        iv = 1'b1;
        ib = 12'($urandom_range(0, 4095));
      end
      orr = ($urandom_range(0, 2) != 0);
      will_acc = iv && rdy;
      if (ov && orr) begin
        chk("rnd_queue_nonempty", 32'(q.size() != 0), 32'd1);
        v = (q.size() != 0) ? q.pop_front() : 0;
        chk("rnd_bcd4", 32'(b4), 32'(bcd_of(v, 4)));
        chk("rnd_blank4", 32'(k4), 32'(blank_of(v, 4)));
        chk("rnd_ovf4", 32'(of4), 32'd0);
        chk("rnd_bcd3", 32'(b3), 32'(bcd_of(v, 3)));
        chk("rnd_ovf3", 32'(of3), 32'(v >= 1000));
        chk("rnd_blank3", 32'(k3), 32'(blank_of(v, 3)));
        recv++;
      end
      if (will_acc) begin
        if (have_prev) chk("rnd_spacing", 32'((cyc - last_acc) >= 14), 32'd1);
        q.push_back(int'(ib));
        last_acc = cyc;
        have_prev = 1'b1;
      end
      tick;
      if (will_acc) begin
        sent++;
        iv = 1'b0;
        ib = 12'($urandom);
      end
    end
    orr = 1'b0;
    chk("rnd_sent", 32'(sent), 32'd1500);
    chk("rnd_recv", 32'(recv), 32'd1500);
    chk("rnd_queue_empty", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
